vid_pix_stage: RTL
==================

# vid_pix_stage

Parametrised pixel-processing stage for the pixel-clock domain, sitting between the DVI-to-RGB converter output and the RGB-to-VGA converter input. It tracks raster position, applies a saturating per-channel signed offset, and counts bright pixels inside a programmable region of interest (ROI) for band detection. It also delays VDE/HSYNC/VSYNC so they stay aligned with the data.

## Interface
- `CW`, 8: bits per colour channel.
- `NCH`, 3: number of channels; the data bus is `NCH*CW` bits, channel 0 in the LSBs.
- `XW`, 12: width of the x position counter and the ROI x bounds.
- `YW`, 11: width of the y position counter and the ROI y bounds.
- `SW`, 22: width of the ROI pixel count.
- `SYNC_POL`, 1'b1: asserted level of `hsync_i` / `vsync_i`.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_i`  in  NCH*CW  input pixel.
- `vde_i`  in  1  video data enable.
- `hsync_i`  in  1  horizontal sync.
- `vsync_i`  in  1  vertical sync.
- `off_i`  in  NCH*(CW+1)  per-channel signed two's-complement offset; quasi-static.
- `roi_x0_i`, `roi_x1_i`  in  XW  inclusive ROI column bounds.
- `roi_y0_i`, `roi_y1_i`  in  YW  inclusive ROI row bounds.
- `thr_i`  in  CW  brightness threshold.
- `data_o`  out  NCH*CW  processed pixel.
- `vde_o`, `hsync_o`, `vsync_o`  out  1  timing signals delayed to match `data_o`.
- `cnt_o`  out  SW  ROI bright-pixel count for the last complete frame.
- `cnt_vld_o`  out  1  one-cycle pulse when `cnt_o` updates.

## Operation
- **Position**
  - `x` increments on each cycle with `vde_i`=1 and saturates at 2^XW-1.
  - On a `vde_i` falling edge: `x`→0 and `y` increments, saturating at 2^YW-1.
  - On a `vsync_i` assertion edge (transition to `SYNC_POL`): `y`→0 and `x`→0.
- **Offset**
  - Per channel: `sum = data + sext(off)`, computed in CW+2 bits.
  - `sum < 0` → 0; `sum > 2^CW-1` → 2^CW-1; otherwise `sum`. The result never wraps.
- **ROI shadowing**
  - `roi_*` and `thr_i` are captured into shadow registers on the vsync assertion edge.
  - Mid-frame changes take effect from the next frame only.
- **ROI membership**
  - A pixel is in the ROI when `vde`=1, x0≤x≤x1 and y0≤y≤y1.
  - x0>x1 or y0>y1 defines an empty ROI; the count is then 0.
- **Bright test**
  - A pixel is bright when the maximum of its offset-corrected channels is ≥ shadow threshold.
  - The accumulator increments for each in-ROI bright pixel and saturates at 2^SW-1.
- **Frame FSM**
  - States: `WAIT_SYNC` (reset state), `ACTIVE`.
  - `WAIT_SYNC` → `ACTIVE` on the first vsync assertion edge; the accumulator clears and shadows load.
  - In `ACTIVE`, each vsync assertion edge does the following in the same cycle:
    - `cnt_o` ← accumulator;
    - `cnt_vld_o` pulses;
    - the accumulator clears;
    - shadows reload.
  - A bright pixel coincident with the vsync edge is not counted; real video has `vde`=0 during vsync.
  - No `cnt_vld_o` is issued for the partial frame after reset.

## Timing
- Latency is exactly 2 cycles from `data_i`/`vde_i`/`hsync_i`/`vsync_i` to the corresponding outputs.
  - Stage 1: offset sum, position/ROI compare.
  - Stage 2: saturation, overlay, bright test.
- Throughput is one pixel per clock, with no stalls.
- Reset values, all applied asynchronously:
  - `data_o`=0, `vde_o`=0, `cnt_o`=0, `cnt_vld_o`=0.
  - `hsync_o`=`vsync_o`=~SYNC_POL (deasserted).
  - Counters 0, FSM in `WAIT_SYNC`.
- `cnt_vld_o` rises 2 cycles after the `vsync_i` assertion edge, aligned with `vsync_o`.
- Reset asserted mid-frame: all pipeline contents are discarded. After release, outputs follow input with 2-cycle latency, and stats resume only after the next vsync edge.

## Configuration
- `VID_ROI_OVERLAY_EN` defined:
  - In-ROI pixels with x∈{x0,x1} or y∈{y0,y1} output all-ones on every channel (white box) in stage 2.
  - The bright test uses the pre-overlay value.
- Undefined: no overlay logic is built, and `data_o` is always the offset-corrected pixel.
- Latency is 2 cycles in both cases.

## Structure
- Package `vid_pkg`:
  - `VID_LAT` = 2;
  - typedef `frame_st_t` {`WAIT_SYNC`, `ACTIVE`};
  - saturating-add function `sat_add`, parameterised via CW by the caller.
- Sub-module `vid_pos_cnt`:
  - contains edge detection, the x/y counters and the vsync-edge strobe;
  - instantiated once, with its strobe feeding the frame FSM.

## Test plan
- **Offset saturation:** CW=8, `off`={+10, −10, 0}, data={250, 5, 128} → `data_o`={255, 0, 128} two cycles later.
- **Latency/alignment:** random 16×4 raster → outputs equal inputs delayed exactly 2 cycles; `hsync_o`/`vsync_o`/`vde_o` bit-exact shifted.
- **ROI count:** 16×8 frame, ROI x 4..7, y 2..3, all pixels 200, thr=100 → after the 2nd vsync edge `cnt_o`=8 with one `cnt_vld_o` pulse; no pulse at the 1st edge.
- **Shadowing and empty ROI:**
  - set x0=9, x1=3 mid-frame → the current frame still reports 8;
  - the following frame reports 0.
- **Overlay** (`VID_ROI_OVERLAY_EN`):
  - ROI border pixels → 0xFFFFFF;
  - ROI interior unchanged;
  - the count equals the non-overlay build.
- **Reset mid-line:**
  - assert `rst_n`=0 at x=5 → all outputs at reset values immediately;
  - after release, no `cnt_vld_o` until the second vsync edge.

Source files
------------

// File: rtl/vid_pkg.sv
// vid_pkg: shared latency constant, frame FSM encoding and the
// saturating-add helper used by the pixel stage.
package vid_pkg;

   localparam int VID_LAT = 2;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      ACTIVE    = 1'b1
   } frame_st_t;

   // Clamp a+b into [0, 2^cw-1]; the caller truncates the result to cw bits.
   function automatic logic [31:0] sat_add(input logic signed [31:0] a,
                                           input logic signed [31:0] b,
                                           input int                 cw);
      logic signed [31:0] s;
      logic signed [31:0] mx;
      s  = a + b;
      mx = (32'sd1 <<< cw) - 32'sd1;
      if (s < 32'sd0)
         sat_add = '0;
      else if (s > mx)
         sat_add = mx;
      else
         sat_add = s;
   endfunction

endpackage

// File: rtl/vid_pos_cnt.sv
// vid_pos_cnt: raster position tracker. Detects vde falling edges and
// vsync assertion edges, runs saturating x/y counters and exposes the
// vsync-edge strobe that drives the frame FSM and ROI shadow reload.
module vid_pos_cnt #(
   parameter int   XW       = 12,
   parameter int   YW       = 11,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_vde,
   input  logic          i_vsync,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_vs_edge
);
   import vid_pkg::*;

   logic          r_vs_on;
   logic          r_vde;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_vs_on;
   logic          w_vde_fall;

   assign w_vs_on    = (i_vsync == SYNC_POL);
   assign o_vs_edge  = w_vs_on && !r_vs_on;
   assign w_vde_fall = r_vde && !i_vde;
   assign o_x        = r_x;
   assign o_y        = r_y;

   // Edge history plus x/y counters; vsync edge wins over line end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_on <= 1'b0;
         r_vde   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         r_vs_on <= w_vs_on;
         r_vde   <= i_vde;
         if (o_vs_edge) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_vde_fall) begin
            r_x <= '0;
            if (r_y != '1)
               r_y <= r_y + YW'(1);
         end else if (i_vde && (r_x != '1)) begin
            r_x <= r_x + XW'(1);
         end
      end
   end

endmodule

// File: rtl/vid_pix_stage.sv
// vid_pix_stage: two-stage pixel pipeline. Stage 1 forms the per-channel
// offset sum and the ROI membership; stage 2 saturates, optionally draws
// the ROI box, and runs the bright-pixel accumulator.
// Optional feature: define VID_ROI_OVERLAY_EN to paint the ROI border white.
module vid_pix_stage #(
   parameter int   CW       = 8,
   parameter int   NCH      = 3,
   parameter int   XW       = 12,
   parameter int   YW       = 11,
   parameter int   SW       = 22,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH*CW-1:0]   data_i,
   input  logic                vde_i,
   input  logic                hsync_i,
   input  logic                vsync_i,
   input  logic [NCH*(CW+1)-1:0] off_i,
   input  logic [XW-1:0]       roi_x0_i,
   input  logic [XW-1:0]       roi_x1_i,
   input  logic [YW-1:0]       roi_y0_i,
   input  logic [YW-1:0]       roi_y1_i,
   input  logic [CW-1:0]       thr_i,
   output logic [NCH*CW-1:0]   data_o,
   output logic                vde_o,
   output logic                hsync_o,
   output logic                vsync_o,
   output logic [SW-1:0]       cnt_o,
   output logic                cnt_vld_o
);
   import vid_pkg::*;

   logic [XW-1:0]          w_x;
   logic [YW-1:0]          w_y;
   logic                   w_vs_edge;
   logic [XW-1:0]          r_sx0, r_sx1;
   logic [YW-1:0]          r_sy0, r_sy1;
   logic [CW-1:0]          r_sthr;
   logic signed [CW+1:0]   w_sum  [NCH];
   logic signed [CW+1:0]   r1_sum [NCH];
   logic                   w_inroi;
   logic                   r1_inroi;
   logic                   r1_vs_edge;
   logic [VID_LAT-1:0]     r_vde_p, r_hs_p, r_vs_p;
   logic [NCH-1:0][CW-1:0] w_sat;
   logic [NCH-1:0][CW-1:0] r_data;
   logic [CW-1:0]          w_max;
   logic                   w_bright;
   logic [SW-1:0]          r_acc, r_cnt;
   logic                   r_cnt_vld;
   frame_st_t              r_st, w_st_nxt;
   logic                   w_cnt_ld, w_acc_clr, w_acc_en;

   vid_pos_cnt #(.XW(XW), .YW(YW), .SYNC_POL(SYNC_POL)) u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_vde     (vde_i),
      .i_vsync   (vsync_i),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_vs_edge (w_vs_edge)
   );

   // Per-channel sum in CW+2 bits (never wraps), clamped one stage later.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [CW-1:0] w_d;
      logic [CW:0]   w_o;
      assign w_d      = data_i[c*CW +: CW];
      assign w_o      = off_i[c*(CW+1) +: CW+1];
      assign w_sum[c] = $signed({2'b00, w_d}) + $signed({w_o[CW], w_o});
      assign w_sat[c] = CW'(sat_add(32'(r1_sum[c]), 32'sd0, CW));
   end

   // An inverted bound pair can never match, so it naturally gives an empty ROI.
   assign w_inroi = vde_i && (w_x >= r_sx0) && (w_x <= r_sx1) &&
                    (w_y >= r_sy0) && (w_y <= r_sy1);

   // ROI/threshold shadows so mid-frame edits only take effect next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sx0  <= '0;
         r_sx1  <= '0;
         r_sy0  <= '0;
         r_sy1  <= '0;
         r_sthr <= '0;
      end else if (w_vs_edge) begin
         r_sx0  <= roi_x0_i;
         r_sx1  <= roi_x1_i;
         r_sy0  <= roi_y0_i;
         r_sy1  <= roi_y1_i;
         r_sthr <= thr_i;
      end
   end

   // Stage 1 register: raw sums, ROI hit and the vsync-edge strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) r1_sum[c] <= '0;
         r1_inroi   <= 1'b0;
         r1_vs_edge <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) r1_sum[c] <= w_sum[c];
         r1_inroi   <= w_inroi;
         r1_vs_edge <= w_vs_edge;
      end
   end

   // Timing signals ride a VID_LAT-deep shift register to stay with the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vde_p <= '0;
         r_hs_p  <= {VID_LAT{~SYNC_POL}};
         r_vs_p  <= {VID_LAT{~SYNC_POL}};
      end else begin
         r_vde_p <= {r_vde_p[VID_LAT-2:0], vde_i};
         r_hs_p  <= {r_hs_p[VID_LAT-2:0], hsync_i};
         r_vs_p  <= {r_vs_p[VID_LAT-2:0], vsync_i};
      end
   end

   // Brightest corrected channel, taken before any overlay.
   always_comb begin
      w_max = '0;
      for (int c = 0; c < NCH; c++)
         if (w_sat[c] > w_max) w_max = w_sat[c];
   end
   assign w_bright = (w_max >= r_sthr);

`ifdef VID_ROI_OVERLAY_EN
   logic w_border;
   logic r1_border;
   assign w_border = w_inroi && ((w_x == r_sx0) || (w_x == r_sx1) ||
                                 (w_y == r_sy0) || (w_y == r_sy1));

   // Stage 1 register for the ROI border flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r1_border <= 1'b0;
      else        r1_border <= w_border;
   end
`endif

   // Stage 2 data register: saturated pixel, white on the ROI border if built.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_data <= '0;
      else
`ifdef VID_ROI_OVERLAY_EN
         r_data <= r1_border ? '1 : w_sat;
`else
         r_data <= w_sat;
`endif
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_st <= WAIT_SYNC;
      else        r_st <= w_st_nxt;
   end

   // Frame FSM next state: first vsync edge after reset arms statistics.
   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         WAIT_SYNC: if (r1_vs_edge) w_st_nxt = ACTIVE;
         default:   w_st_nxt = r_st;
      endcase
   end

   // Frame FSM outputs; the strobe is taken at stage 2 so the report lines up with vsync_o.
   always_comb begin
      w_acc_clr = r1_vs_edge;
      w_cnt_ld  = 1'b0;
      w_acc_en  = 1'b0;
      if (r_st == ACTIVE) begin
         w_cnt_ld = r1_vs_edge;
         w_acc_en = r1_inroi && w_bright;
      end
   end

   // Accumulator and frame report; clear wins so the edge pixel is never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_cnt_vld <= 1'b0;
      end else begin
         r_cnt_vld <= w_cnt_ld;
         if (w_cnt_ld) r_cnt <= r_acc;
         if (w_acc_clr)
            r_acc <= '0;
         else if (w_acc_en && (r_acc != '1))
            r_acc <= r_acc + SW'(1);
      end
   end

   assign data_o    = r_data;
   assign vde_o     = r_vde_p[VID_LAT-1];
   assign hsync_o   = r_hs_p[VID_LAT-1];
   assign vsync_o   = r_vs_p[VID_LAT-1];
   assign cnt_o     = r_cnt;
   assign cnt_vld_o = r_cnt_vld;

endmodule
